// File: rtl/led_mode_arbiter.sv
// Shares the user LEDs among CPU gpio, the slide switches and a heartbeat walker; a debounced button cycles the source.
// Latency: led_o is registered one cycle after its source; a mode change shows one dark cycle before the new source.
module led_mode_arbiter #(
    parameter int DEBOUNCE_CYCLES  = 1000000,
    parameter int HEARTBEAT_CYCLES = 25000000,
    parameter int LED_W            = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             btn_i,
    input  logic [LED_W-1:0] cpu_led_i,
    input  logic [LED_W-1:0] sw_i,
    output logic [LED_W-1:0] led_o,
    output logic [1:0]       mode_o,
    output logic             btn_pulse_o
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int HB_W  = $clog2(HEARTBEAT_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(HEARTBEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_CPU       = 2'd0,
        MODE_SWITCH    = 2'd1,
        MODE_HEARTBEAT = 2'd2,
        MODE_BAD       = 2'd3
    } mode_t;

    logic [1:0]       sync_q;
    logic             btn_s;
    logic             deb_lvl;
    logic [DEB_W-1:0] deb_cnt;
    logic [HB_W-1:0]  hb_cnt;
    logic [LED_W-1:0] hb_pat;
    logic             blank;
    mode_t            mode_q;
    mode_t            mode_d;
    logic [LED_W-1:0] src;

    // btn_i is asynchronous; only the second flop is ever looked at
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

    assign btn_s = sync_q[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            deb_lvl     <= 1'b0;
            deb_cnt     <= '0;
            btn_pulse_o <= 1'b0;
        end else begin
            btn_pulse_o <= 1'b0;
            if (btn_s == deb_lvl) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_lvl     <= btn_s;
                deb_cnt     <= '0;
                btn_pulse_o <= btn_s;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hb_cnt <= '0;
            hb_pat <= LED_W'(1);
        end else if (hb_cnt == HB_LAST) begin
            hb_cnt <= '0;
            hb_pat <= {hb_pat[LED_W-2:0], hb_pat[LED_W-1]};
        end else begin
            hb_cnt <= hb_cnt + HB_W'(1);
        end
    end

    always_comb begin
        mode_d = mode_q;
        src    = '0;
        case (mode_q)
            MODE_CPU: begin
                src = cpu_led_i;
                if (btn_pulse_o) mode_d = MODE_SWITCH;
            end
            MODE_SWITCH: begin
                src = sw_i;
                if (btn_pulse_o) mode_d = MODE_HEARTBEAT;
            end
            MODE_HEARTBEAT: begin
                src = hb_pat;
                if (btn_pulse_o) mode_d = MODE_CPU;
            end
            default: mode_d = MODE_CPU;
        endcase
    end

    // blank marks the cycle after a mode change so the LEDs go dark once before the new source
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q <= MODE_CPU;
            blank  <= 1'b0;
            led_o  <= '0;
        end else begin
            mode_q <= mode_d;
            blank  <= (mode_d != mode_q);
            led_o  <= blank ? '0 : src;
        end
    end

    assign mode_o = mode_q;

endmodule
